// File: rtl/seq_fsm_pkg.sv
// seq_fsm_pkg: shared types and default constants for the
// programmable sequence detector and its pattern register file.
package seq_fsm_pkg;

   typedef enum logic {
      RESET_ON_MISS   = 1'b0,
      RESTART_ON_MISS = 1'b1
   } miss_mode_e;

   localparam int SYM_W_DEF = 2;
   localparam int DEPTH_DEF = 2;
   localparam int CNT_W_DEF = 8;

   // Entry 0 in the LSBs: channel 0 first, then channel 1.
   localparam logic [DEPTH_DEF*SYM_W_DEF-1:0] INIT_PATTERN_DEF =
      {2'b10, 2'b01};

   typedef logic [SYM_W_DEF-1:0] sym_t;

endpackage

// File: rtl/seq_pattern_regs.sv
// seq_pattern_regs: DEPTH x SYM_W pattern register file.
// Ports: clk, rst (sync, active-high), we/idx/wsym write port,
// pat[] parallel read of every entry.
module seq_pattern_regs
   import seq_fsm_pkg::*;
#(
   parameter int SYM_W = SYM_W_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter logic [DEPTH*SYM_W-1:0] INIT_PATTERN = INIT_PATTERN_DEF,
   localparam int IW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [IW-1:0]    idx,
   input  logic [SYM_W-1:0] wsym,
   output logic [SYM_W-1:0] pat [DEPTH]
);

   // An idx with no matching entry simply writes nothing.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (rst)
            pat[i] <= INIT_PATTERN[i*SYM_W +: SYM_W];
         else if (we && idx == IW'(i))
            pat[i] <= wsym;
      end
   end

endmodule

// File: rtl/seq_detect_fsm.sv
// seq_detect_fsm: programmable sequence detector with two miss
// recovery modes and a saturating match counter.
// Ports: clk, rst (sync, active-high); cfg_we/cfg_idx/cfg_sym pattern
// write; mode (0 reset, 1 restart on miss); in_valid/in_sym input;
// a (progress != 0), b (armed), match pulse, state (progress index),
// match_cnt. All outputs registered.
module seq_detect_fsm
   import seq_fsm_pkg::*;
#(
   parameter int SYM_W = SYM_W_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int CNT_W = CNT_W_DEF,
   parameter logic [DEPTH*SYM_W-1:0] INIT_PATTERN = INIT_PATTERN_DEF,
   localparam int IW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [IW-1:0]    cfg_idx,
   input  logic [SYM_W-1:0] cfg_sym,
   input  logic             mode,
   input  logic             in_valid,
   input  logic [SYM_W-1:0] in_sym,
   output logic             a,
   output logic             b,
   output logic             match,
   output logic [IW-1:0]    state,
   output logic [CNT_W-1:0] match_cnt
);

   localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);
   localparam logic [IW-1:0] ONE  = IW'(1);

   logic [SYM_W-1:0] pat [DEPTH];
   logic [IW-1:0]    p_q;
   logic [IW-1:0]    p_d;
   logic             hit;
   logic             a_d;
   logic             b_d;
   logic [CNT_W-1:0] cnt_d;
   logic             eq;
   logic             eq0;
   miss_mode_e       mode_e;

   seq_pattern_regs #(
      .SYM_W        (SYM_W),
      .DEPTH        (DEPTH),
      .INIT_PATTERN (INIT_PATTERN)
   ) u_pat (
      .clk  (clk),
      .rst  (rst),
      .we   (cfg_we),
      .idx  (cfg_idx),
      .wsym (cfg_sym),
      .pat  (pat)
   );

   assign mode_e = miss_mode_e'(mode);
   assign eq     = (in_sym == pat[p_q]);
   assign eq0    = (in_sym == pat[0]);
   assign state  = p_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         p_q       <= '0;
         a         <= 1'b0;
         b         <= 1'b0;
         match     <= 1'b0;
         match_cnt <= '0;
      end else begin
         p_q       <= p_d;
         a         <= a_d;
         b         <= b_d;
         match     <= hit;
         match_cnt <= cnt_d;
      end
   end

   // A config write clears progress and masks in_valid. The completing
   // symbol always returns to 0 so it never seeds the next match.
   always_comb begin
      p_d = p_q;
      hit = 1'b0;
      if (cfg_we) begin
         p_d = '0;
      end else if (in_valid) begin
         unique case (1'b1)
            eq && (p_q == LAST): begin
               p_d = '0;
               hit = 1'b1;
            end
            eq && (p_q != LAST):
               p_d = p_q + ONE;
            !eq && (mode_e == RESTART_ON_MISS) && eq0:
               p_d = ONE;
            default:
               p_d = '0;
         endcase
      end
   end

   // Outputs are derived from next progress so they line up with state.
   always_comb begin
      a_d   = (p_d != '0);
      b_d   = (p_d == LAST);
      cnt_d = match_cnt;
      if (hit && (match_cnt != '1))
         cnt_d = match_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_seq_detect_fsm.sv
// tb_seq_detect_fsm: vector table, corner sequences and random
// stimulus for two detector instances against a reference model.
module tb_seq_detect_fsm;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       we0, we1, md0, md1, v0, v1;
   logic [0:0] idx0;
   logic [1:0] idx1;
   logic [1:0] cs0, cs1, s0, s1;
   logic       a0, b0, m0, a1, b1, m1;
   logic [0:0] st0;
   logic [1:0] st1;
   logic [7:0] c0;
   logic [1:0] c1;

   seq_detect_fsm dut0 (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (we0),
      .cfg_idx   (idx0),
      .cfg_sym   (cs0),
      .mode      (md0),
      .in_valid  (v0),
      .in_sym    (s0),
      .a         (a0),
      .b         (b0),
      .match     (m0),
      .state     (st0),
      .match_cnt (c0)
   );

   seq_detect_fsm #(
      .SYM_W        (2),
      .DEPTH        (3),
      .CNT_W        (2),
      .INIT_PATTERN ({2'b10, 2'b01, 2'b01})
   ) dut1 (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (we1),
      .cfg_idx   (idx1),
      .cfg_sym   (cs1),
      .mode      (md1),
      .in_valid  (v1),
      .in_sym    (s1),
      .a         (a1),
      .b         (b1),
      .match     (m1),
      .state     (st1),
      .match_cnt (c1)
   );

   // Reference model: per-unit progress, pattern and counter.
   int dep  [2] = '{2, 3};
   int cmax [2] = '{255, 3};
   int ipat [2][3] = '{'{1, 2, 0}, '{1, 1, 2}};
   int mpat [2][3];
   int mp   [2];
   int mcnt [2];
   int mm   [2];

   int pass_n = 0;
   int tot_n  = 0;
   int act_st, act_m, act_c;

   typedef struct {
      int u, we, idx, sym, md, v, s;
      int es, em, ec;
   } vec_t;
   vec_t tv [$];

   function automatic vec_t mk(int u, int we, int idx, int sym,
                               int md, int v, int s,
                               int es, int em, int ec);
      vec_t r;
      r.u = u; r.we = we; r.idx = idx; r.sym = sym;
      r.md = md; r.v = v; r.s = s;
      r.es = es; r.em = em; r.ec = ec;
      return r;
   endfunction

   task automatic chk(string nm, int act, int exp);
      tot_n++;
      if (act == exp) pass_n++;
      else $display("FAIL %s: got %0d want %0d at %0t",
                    nm, act, exp, $time);
   endtask

   task automatic mstep(int u, bit r, bit we, int idx, int sym,
                        bit md, bit v, int s);
      mm[u] = 0;
      if (r) begin
         mp[u] = 0;
         mcnt[u] = 0;
         for (int i = 0; i < 3; i++) mpat[u][i] = ipat[u][i];
      end else if (we) begin
         if (idx < dep[u]) mpat[u][idx] = sym;
         mp[u] = 0;
      end else if (v) begin
         if (s == mpat[u][mp[u]]) begin
            if (mp[u] == dep[u] - 1) begin
               mp[u] = 0;
               mm[u] = 1;
               if (mcnt[u] < cmax[u]) mcnt[u]++;
            end else begin
               mp[u]++;
            end
         end else if (md && s == mpat[u][0]) begin
            mp[u] = 1;
         end else begin
            mp[u] = 0;
         end
      end
   endtask

   task automatic cyc(bit r, int u, bit we, int idx, int sym,
                      bit md, bit v, int s);
      int st, aa, bb, mt, ct;
      rst = r;
      we0 = 1'b0; v0 = 1'b0; md0 = 1'b0;
      we1 = 1'b0; v1 = 1'b0; md1 = 1'b0;
      if (u == 0) begin
         we0 = we; idx0 = 1'(idx); cs0 = 2'(sym);
         md0 = md; v0 = v; s0 = 2'(s);
      end else begin
         we1 = we; idx1 = 2'(idx); cs1 = 2'(sym);
         md1 = md; v1 = v; s1 = 2'(s);
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (k == u) mstep(k, r, we, idx, sym, md, v, s);
         else mstep(k, r, 1'b0, 0, 0, 1'b0, 1'b0, 0);
      end
      #1;
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         if (k == 0) begin
            st = int'(st0); aa = int'(a0); bb = int'(b0);
            mt = int'(m0); ct = int'(c0);
         end else begin
            st = int'(st1); aa = int'(a1); bb = int'(b1);
            mt = int'(m1); ct = int'(c1);
         end
         chk($sformatf("u%0d state", k), st, mp[k]);
         chk($sformatf("u%0d a", k), aa, int'(mp[k] != 0));
         chk($sformatf("u%0d b", k), bb, int'(mp[k] == dep[k] - 1));
         chk($sformatf("u%0d match", k), mt, mm[k]);
         chk($sformatf("u%0d cnt", k), ct, mcnt[k]);
         if (k == u) begin
            act_st = st; act_m = mt; act_c = ct;
         end
      end
   endtask

   int satx [5] = '{1, 2, 3, 3, 3};

   initial begin
      rst = 1'b1;
      we0 = 0; we1 = 0; md0 = 0; md1 = 0; v0 = 0; v1 = 0;
      idx0 = '0; idx1 = '0; cs0 = '0; cs1 = '0; s0 = '0; s1 = '0;

      // u, we, idx, sym, md, v, s, exp state, exp match, exp cnt
      tv.push_back(mk(0,0,0,0,0,1,1, 1,0,0));
      tv.push_back(mk(0,0,0,0,0,1,2, 0,1,1));
      tv.push_back(mk(0,0,0,0,0,1,1, 1,0,1));
      tv.push_back(mk(0,0,0,0,0,1,0, 0,0,1));
      tv.push_back(mk(0,0,0,0,0,0,1, 0,0,1));
      tv.push_back(mk(1,0,0,0,1,1,1, 1,0,0));
      tv.push_back(mk(1,0,0,0,1,1,1, 2,0,0));
      tv.push_back(mk(1,0,0,0,1,1,1, 1,0,0));
      tv.push_back(mk(1,0,0,0,1,1,1, 2,0,0));
      tv.push_back(mk(1,0,0,0,1,1,2, 0,1,1));
      tv.push_back(mk(1,0,0,0,0,1,1, 1,0,1));
      tv.push_back(mk(1,0,0,0,0,1,1, 2,0,1));
      tv.push_back(mk(1,0,0,0,0,1,1, 0,0,1));
      tv.push_back(mk(1,0,0,0,0,1,1, 1,0,1));
      tv.push_back(mk(1,0,0,0,0,1,2, 0,0,1));
      tv.push_back(mk(0,1,1,3,0,0,0, 0,0,1));
      tv.push_back(mk(0,0,0,0,0,1,1, 1,0,1));
      tv.push_back(mk(0,0,0,0,0,1,3, 0,1,2));
      tv.push_back(mk(0,0,0,0,0,1,1, 1,0,2));
      tv.push_back(mk(0,0,0,0,0,1,2, 0,0,2));
      tv.push_back(mk(0,0,0,0,0,1,1, 1,0,2));
      tv.push_back(mk(0,1,0,1,0,1,3, 0,0,2));
      tv.push_back(mk(0,0,0,0,0,1,3, 0,0,2));
      tv.push_back(mk(0,0,0,0,1,1,1, 1,0,2));
      tv.push_back(mk(0,0,0,0,1,1,1, 1,0,2));
      tv.push_back(mk(0,0,0,0,1,1,3, 0,1,3));
      tv.push_back(mk(1,1,3,0,0,0,0, 0,0,1));
      tv.push_back(mk(1,0,0,0,0,1,1, 1,0,1));
      tv.push_back(mk(1,0,0,0,0,1,1, 2,0,1));
      tv.push_back(mk(1,0,0,0,0,1,2, 0,1,2));

      cyc(1'b1, 0, 0, 0, 0, 0, 0, 0);
      chk("reset state", act_st, 0);
      chk("reset match", act_m, 0);
      chk("reset cnt", act_c, 0);

      foreach (tv[i]) begin
         cyc(1'b0, tv[i].u, tv[i].we[0], tv[i].idx, tv[i].sym,
             tv[i].md[0], tv[i].v[0], tv[i].s);
         chk($sformatf("tv%0d state", i), act_st, tv[i].es);
         chk($sformatf("tv%0d match", i), act_m, tv[i].em);
         chk($sformatf("tv%0d cnt", i), act_c, tv[i].ec);
      end

      // Saturation with CNT_W=2 on back-to-back patterns.
      cyc(1'b1, 1, 0, 0, 0, 0, 0, 0);
      for (int j = 0; j < 5; j++) begin
         cyc(1'b0, 1, 0, 0, 0, 0, 1, 1);
         cyc(1'b0, 1, 0, 0, 0, 0, 1, 1);
         cyc(1'b0, 1, 0, 0, 0, 0, 1, 2);
         chk($sformatf("sat match %0d", j), act_m, 1);
         chk($sformatf("sat cnt %0d", j), act_c, satx[j]);
      end

      // Zero symbol as a pattern entry.
      cyc(1'b0, 1, 1, 0, 0, 0, 0, 0);
      cyc(1'b0, 1, 0, 0, 0, 0, 1, 0);
      cyc(1'b0, 1, 0, 0, 0, 0, 1, 1);
      cyc(1'b0, 1, 0, 0, 0, 0, 1, 2);
      chk("zero entry match", act_m, 1);

      // Reset mid-sequence restores the initial pattern.
      cyc(1'b0, 0, 1, 1, 3, 0, 0, 0);
      cyc(1'b0, 0, 0, 0, 0, 0, 1, 1);
      chk("pre-rst state", act_st, 1);
      cyc(1'b1, 0, 0, 0, 0, 0, 1, 3);
      chk("mid-rst state", act_st, 0);
      chk("mid-rst match", act_m, 0);
      chk("mid-rst cnt", act_c, 0);
      cyc(1'b0, 0, 0, 0, 0, 0, 1, 1);
      cyc(1'b0, 0, 0, 0, 0, 0, 1, 2);
      chk("init pat restored", act_m, 1);

      // Randomised traffic, biased toward the expected symbol.
      for (int n = 0; n < 800; n++) begin
         int u, idx, sym, s;
         bit r, we, md, v;
         u   = int'($urandom_range(0, 1));
         r   = ($urandom_range(0, 99) == 0);
         we  = ($urandom_range(0, 9) == 0);
         idx = int'(u == 1 ? $urandom_range(0, 3) : $urandom_range(0, 1));
         sym = int'($urandom_range(0, 3));
         md  = $urandom_range(0, 1) == 1;
         v   = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 2) != 0) s = mpat[u][mp[u]];
         else s = int'($urandom_range(0, 3));
         cyc(r, u, we, idx, sym, md, v, s);
      end

      $display("%0d/%0d checks passed", pass_n, tot_n);
      $finish;
   end

endmodule
